// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Sits between the core data port and a single-word req/ack main memory.
module data_cache_ctrl #(
    parameter int unsigned N_LINES        = 64,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Storetype,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int unsigned IDX  = $clog2(N_LINES);
    localparam int unsigned OFF  = $clog2(WORDS_PER_LINE);
    localparam int unsigned TAGW = 32 - IDX - OFF - 2;
    localparam logic [OFF-1:0] LastWord = OFF'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {StIdle, StRefill, StWrite} state_e;

    state_e            state_q, state_d;
    logic [OFF-1:0]    cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;

    logic [N_LINES-1:0] valid_q;
    logic [TAGW-1:0]    tag_q  [N_LINES];
    logic [31:0]        data_q [N_LINES*WORDS_PER_LINE];

    logic [OFF-1:0]  req_off;
    logic [IDX-1:0]  req_idx, lat_idx;
    logic [TAGW-1:0] req_tag, lat_tag;
    logic            hit, wr_hit;
    logic [3:0]      st_strb;
    logic [31:0]     st_data;
    logic            refill_start, refill_we, refill_done, merge_we;

    assign req_off = ALUResult[OFF+1:2];
    assign req_idx = ALUResult[IDX+OFF+1:OFF+2];
    assign req_tag = ALUResult[31:IDX+OFF+2];
    assign lat_idx = addr_q[IDX+OFF+1:OFF+2];
    assign lat_tag = addr_q[31:IDX+OFF+2];

    assign hit    = MemRead & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    // Store hit is judged on the latched address while the write is in flight.
    assign wr_hit = valid_q[lat_idx] & (tag_q[lat_idx] == lat_tag);

    // Byte strobes and lane-replicated store data for the incoming store.
    always_comb begin
        st_strb = 4'b1111;
        st_data = WriteData;
        case (Storetype)
            2'b00: begin
                st_strb = 4'b0001 << ALUResult[1:0];
                st_data = {4{WriteData[7:0]}};
            end
            2'b01: begin
                st_strb = ALUResult[1] ? 4'b1100 : 4'b0011;
                st_data = {2{WriteData[15:0]}};
            end
            default: ;
        endcase
    end

    // Next-state and output decode; reset forces every output quiet.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        stall        = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        mem_wstrb    = 4'h0;
        refill_start = 1'b0;
        refill_we    = 1'b0;
        refill_done  = 1'b0;
        merge_we     = 1'b0;
        ReadData     = hit ? data_q[{req_idx, req_off}] : 32'h0;
        unique case (state_q)
            StIdle: begin
                if (MemWrite) begin
                    stall   = 1'b1;
                    addr_d  = {ALUResult[31:2], 2'b00};
                    wdata_d = st_data;
                    wstrb_d = st_strb;
                    state_d = StWrite;
                end else if (MemRead && !hit) begin
                    stall        = 1'b1;
                    refill_start = 1'b1;
                    addr_d       = {ALUResult[31:OFF+2], {(OFF+2){1'b0}}};
                    cnt_d        = '0;
                    state_d      = StRefill;
                end
            end
            StRefill: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {addr_q[31:OFF+2], cnt_q, 2'b00};
                if (mem_ack) begin
                    refill_we = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LastWord) begin
                        refill_done = 1'b1;
                        state_d     = StIdle;
                    end
                end
            end
            StWrite: begin
                stall     = ~mem_ack;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_wstrb = wstrb_q;
                if (mem_ack) begin
                    merge_we = wr_hit;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (rst) begin
            stall        = 1'b0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr     = 32'h0;
            mem_wdata    = 32'h0;
            mem_wstrb    = 4'h0;
            ReadData     = 32'h0;
            refill_start = 1'b0;
            refill_we    = 1'b0;
            refill_done  = 1'b0;
            merge_we     = 1'b0;
        end
    end

    // Control state and latched request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    // Valid bits: line goes invalid for the whole refill, valid on the last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (refill_start) begin
            valid_q[req_idx] <= 1'b0;
        end else if (refill_done) begin
            valid_q[lat_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: refill fill and store-hit byte merge.
    always_ff @(posedge clk) begin
        if (refill_we) begin
            data_q[{lat_idx, cnt_q}] <= mem_rdata;
        end
        if (refill_done) begin
            tag_q[lat_idx] <= lat_tag;
        end
        if (merge_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    data_q[{lat_idx, addr_q[OFF+1:2]}][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_cache_ctrl.md
# data_cache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller on the memory side of the RISC-V core's data port. It answers the core's MemRead/MemWrite requests, returns ReadData, and asserts stall while it refills a line or writes a store through to main memory. The main-memory side is a single-word request/acknowledge handshake.

## Interface
- N_LINES, 64, number of cache lines (power of two); index width IDX = log2(N_LINES)
- WORDS_PER_LINE, 4, 32-bit words per line (power of two); offset width OFF = log2(WORDS_PER_LINE)
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- MemRead  in  1  core load request
- MemWrite  in  1  core store request; wins if both asserted
- Storetype  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- ALUResult  in  32  byte address from core
- WriteData  in  32  store data, LSB-aligned
- ReadData  out  32  aligned word at ALUResult[31:2]; core extracts bytes
- stall  out  1  core must hold PC and all request inputs while high
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 write, 0 read
- mem_addr  out  32  word-aligned memory address
- mem_wdata  out  32  write data, lane-replicated
- mem_wstrb  out  4  byte enables for writes
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse for the current request

## Operation
- Address split: byte [1:0], word offset [OFF+1:2], index [IDX+OFF+1:OFF+2], tag = remaining upper bits.
- Storage: valid bit, tag, and WORDS_PER_LINE data words per line.
- hit = MemRead & valid[index] & (tag[index] == address tag).
- States: IDLE, REFILL, WRITE.
- IDLE: stall = (MemRead & ~hit) | MemWrite, combinational. On a read hit, ReadData = cached word; no memory traffic. On a read miss, latch the line address, clear the word counter, and go to REFILL. On MemWrite, latch the word address, strobe and lane data, and go to WRITE.
- REFILL: mem_req=1, mem_we=0, mem_addr = {latched tag, index, counter, 2'b00}. On each mem_ack, write mem_rdata into the line word at the counter and increment the counter. On the ack for the last word, set valid and tag and go to IDLE. stall=1 throughout. Valid stays 0 for the line during refill.
- WRITE: mem_req=1, mem_we=1. Hold address, data and strobe until mem_ack. stall = ~mem_ack. On the ack edge:
  - on a hit, merge the strobed bytes into the cached word;
  - on a miss, no allocation;
  - go to IDLE.
- Strobes:
  - byte: 4'b0001 << addr[1:0];
  - half: addr[1] ? 4'b1100 : 4'b0011 (addr[0] ignored; misaligned access unsupported);
  - word: 4'b1111.
- mem_wdata: byte {4{WriteData[7:0]}}, half {2{WriteData[15:0]}}, word WriteData.
- ReadData = 0 when not (MemRead & hit).

## Timing
- Reset (rst high at an edge): state IDLE, counter 0, all valid bits cleared. While rst is high, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, ReadData=0.
- Read hit: zero added latency; stall low in the request cycle.
- Read miss:
  - stall high from the request cycle;
  - WORDS_PER_LINE sequential transactions, word 0 first;
  - one IDLE hit cycle with stall low.
  - Total = 1 + sum of per-word ack latencies + 1 cycles.
- Store: stall high from the request cycle until the mem_ack cycle; the core advances at that cycle's edge.
- mem_req rises the cycle after the request cycle and stays high across back-to-back refill words. Address and data change only on the edge following mem_ack.
- mem_ack is ignored in IDLE.
- Reset mid-REFILL or mid-WRITE: the operation is abandoned, and mem_req drops in the cycle rst is high. Memory shares rst and drops any outstanding transaction.
- Simultaneous MemRead and MemWrite: treated as a store.

## Test plan
- After reset, load 0x100 with mem_ack 2 cycles after each req: four reads at 0x100, 0x104, 0x108, 0x10C. Then stall=0 with ReadData = mem[0x100]. Total 1 + 12 + 1 cycles.
- After that refill, load 0x108: stall=0 in the same cycle, ReadData = mem[0x108], mem_req stays 0.
- Store byte 0xAB at 0x105 (Storetype=00, hit): mem_addr=0x104, mem_wstrb=4'b0010, mem_wdata=0xABABABAB, stall low on the ack cycle. A following load of 0x104 hits and returns byte 1 = 0xAB.
- Store word 0xDEADBEEF at 0x600 (miss): one write transaction. A following load of 0x600 misses and refills.
- Conflict: load 0x100, then 0x500 (same index 0x10), then 0x100. Each load misses, and each refill issues four memory reads.
- Assert rst after 2 refill acks of 0x100: mem_req=0 and stall=0 in the reset cycle. The next load of 0x100 misses and refetches all four words starting at 0x100.
